// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, widths and operand helpers.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int CNT_W     = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic signed [DIV_WIDTH-1:0] v);
    logic [DIV_WIDTH-1:0] r;
    r = v[DIV_WIDTH-1] ? DIV_WIDTH'(-v) : DIV_WIDTH'(v);
    return r;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_in,
  input  logic [DIV_WIDTH-1:0] dvs,
  input  logic                 dvd_bit,
  output logic [DIV_WIDTH-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIV_WIDTH:0] trial;
  logic [DIV_WIDTH:0] diff;

  // The trial value is one bit wider than the remainder; a borrow out of bit DIV_WIDTH means "does not fit".
  always_comb begin
    trial   = {rem_in, dvd_bit};
    diff    = trial - {1'b0, dvs};
    q_bit   = ~diff[DIV_WIDTH];
    rem_out = q_bit ? diff[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider (DIV/DIVU), fixed 34-cycle latency.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses the iteration and finishes in 2 cycles.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sign,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 dz
);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;
  logic [DIV_WIDTH-1:0] quot_q, quot_d;
  logic [DIV_WIDTH-1:0] remo_q, remo_d;

  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 dz_pend_q, dz_pend_d;

  logic [DIV_WIDTH-1:0] step_rem;
  logic                 step_qbit;
  logic [DIV_WIDTH-1:0] mag_dvd;
  logic [DIV_WIDTH-1:0] mag_dvs;
  logic                 dvs_zero;

  assign dvs_zero = (divisor == '0);
  assign mag_dvd  = sign ? abs_val(dividend) : dividend;
  assign mag_dvs  = sign ? abs_val(divisor)  : divisor;

  div_step u_step (
    .rem_in  (rem_q),
    .dvs     (dvs_q),
    .dvd_bit (dvd_q[DIV_WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    dvd_q     <= dvd_d;
    dvs_q     <= dvs_d;
    q_neg_q   <= q_neg_d;
    r_neg_q   <= r_neg_d;
    dz_pend_q <= dz_pend_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = dvs_zero ? ST_FIX : ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_RUN:  if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // dvd_q shifts out dividend bits MSB first while quotient bits shift in at the bottom.
  always_comb begin
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dz_pend_d = dz_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d     = '0;
          rem_d     = '0;
          dvd_d     = mag_dvd;
          dvs_d     = mag_dvs;
          q_neg_d   = sign & (dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1]);
          r_neg_d   = sign & dividend[DIV_WIDTH-1];
          dz_pend_d = dvs_zero;
`ifdef DIV_ZERO_FAST_EN
          // Preload what 32 iterations against a zero divisor would leave behind.
          if (dvs_zero) begin
            rem_d = mag_dvd;
            dvd_d = '1;
          end
`endif
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        rem_d = step_rem;
        dvd_d = {dvd_q[DIV_WIDTH-2:0], step_qbit};
      end
      ST_FIX: begin
        cnt_d  = '0;
        quot_d = q_neg_q ? (~dvd_q + DIV_WIDTH'(1)) : dvd_q;
        remo_d = r_neg_q ? (~rem_q + DIV_WIDTH'(1)) : rem_q;
        dz_d   = dz_pend_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    dz        = dz_q;
    quotient  = quot_q;
    remainder = remo_q;
  end

endmodule
